// File: rtl/gshare_predictor_param.sv
// gshare_predictor_param -- gshare branch direction predictor.
// The PHT of 2-bit saturating counters is indexed by the PC slice XOR the
// global history register (GHR). After reset an INIT sweep writes CNT_INIT
// into every entry, one per cycle, before the predictor accepts traffic.
// Optional macro GSHARE_STATS_EN adds the pred_cnt / mispred_cnt counters.
module gshare_predictor_param #(
  parameter int         PC_W     = 32,
  parameter int         IDX_W    = 10,
  parameter int         HIST_W   = 10,
  parameter int         PC_LSB   = 2,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              train_valid,
  input  logic [PC_W-1:0]   train_pc,
  input  logic [HIST_W-1:0] train_hist,
  input  logic              train_taken,
  input  logic              train_mispredict
`ifdef GSHARE_STATS_EN
  ,
  output logic [31:0]       pred_cnt,
  output logic [31:0]       mispred_cnt
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  sweep;
  logic [HIST_W-1:0] ghr, ghr_nxt;
  logic [1:0]        pht [DEPTH];
  logic              run;
  logic [IDX_W-1:0]  pred_idx, train_idx;
  logic [1:0]        train_cnt, train_cnt_nxt;
  logic              recover;

  // Only the index slice of each PC matters; fold the rest away.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, train_pc};

  // Index: PC slice XOR zero-extended history.
  assign pred_idx  = pred_pc[PC_LSB +: IDX_W]  ^ IDX_W'(ghr);
  assign train_idx = train_pc[PC_LSB +: IDX_W] ^ IDX_W'(train_hist);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // FSM next state: leave INIT on the edge that writes the last entry.
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && sweep == '1) state_nxt = S_RUN;
  end

  // FSM outputs.
  always_comb begin
    init_busy = (state == S_INIT);
    run       = (state == S_RUN);
  end

  // Sweep counter walks entries 0..DEPTH-1 while in INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sweep <= '0;
    else if (state == S_INIT)  sweep <= sweep + 1'b1;
  end

  // Zero-latency read; the array is read before any same-cycle write lands.
  assign pred_taken = run & pht[pred_idx][1];
  assign pred_hist  = ghr;

  // Saturating counter update for the trained entry.
  always_comb begin
    train_cnt     = pht[train_idx];
    train_cnt_nxt = train_cnt;
    if (train_taken) begin
      if (train_cnt != 2'b11) train_cnt_nxt = train_cnt + 2'b01;
    end else begin
      if (train_cnt != 2'b00) train_cnt_nxt = train_cnt - 2'b01;
    end
  end

  // PHT write port: init sweep or training; no reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (init_busy)        pht[sweep]     <= CNT_INIT;
    else if (train_valid) pht[train_idx] <= train_cnt_nxt;
  end

  // GHR next value: mispredict recovery overrides speculative shift.
  // Shift-and-OR form keeps HIST_W=1 legal without slicing [-1:0].
  assign recover = train_valid & train_mispredict;
  always_comb begin
    ghr_nxt = ghr;
    if (run) begin
      if (recover)         ghr_nxt = (train_hist << 1) | HIST_W'(train_taken);
      else if (pred_valid) ghr_nxt = (ghr << 1) | HIST_W'(pred_taken);
    end
  end

  // GHR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr <= '0;
    else        ghr <= ghr_nxt;
  end

`ifdef GSHARE_STATS_EN
  // Saturating statistics, frozen while the sweep runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_cnt    <= '0;
      mispred_cnt <= '0;
    end else if (run) begin
      if (pred_valid && pred_cnt != '1)   pred_cnt    <= pred_cnt + 32'd1;
      if (recover && mispred_cnt != '1)   mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Self-checking bench for gshare_predictor_param (IDX_W=8, HIST_W=8) against
// an array-based reference model of the predictor's rules.
module tb_gshare_predictor_param;
  localparam int IDX_W  = 8;
  localparam int HIST_W = 8;
  localparam int DEPTH  = 1 << IDX_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_busy, pt, pv, tv, tt, tm;
  logic [31:0] ppc, tpc;
  logic [7:0]  ph, th;
`ifdef GSHARE_STATS_EN
  logic [31:0] pred_cnt, mispred_cnt;
`endif

  always #5 clk = ~clk;

  gshare_predictor_param #(
    .PC_W(32), .IDX_W(IDX_W), .HIST_W(HIST_W), .PC_LSB(2), .CNT_INIT(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
    .pred_valid(pv), .pred_pc(ppc), .pred_taken(pt), .pred_hist(ph),
    .train_valid(tv), .train_pc(tpc), .train_hist(th),
    .train_taken(tt), .train_mispredict(tm)
`ifdef GSHARE_STATS_EN
    , .pred_cnt(pred_cnt), .mispred_cnt(mispred_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int     m_pht [DEPTH];
  int     m_ghr;
  int     m_busy;
  longint m_pc, m_mc;

  function automatic int m_idx(input logic [31:0] pc, input int h);
    return (int'(pc >> 2) & (DEPTH - 1)) ^ h;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return (m_busy == 0) && (m_pht[m_idx(pc, m_ghr)] >= 2);
  endfunction

  task automatic model_reset();
    m_ghr = 0; m_busy = DEPTH; m_pc = 0; m_mc = 0;
    for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
  endtask

  // One clock edge of the model, using the inputs currently driven.
  task automatic model_step();
    bit p;
    int k;
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      p = m_pred(ppc);
      if (pv) m_pc++;
      if (tv && tm) m_mc++;
      if (tv) begin
        k = m_idx(tpc, int'(th));
        if (tt) m_pht[k] = (m_pht[k] == 3) ? 3 : m_pht[k] + 1;
        else    m_pht[k] = (m_pht[k] == 0) ? 0 : m_pht[k] - 1;
      end
      if (tv && tm)  m_ghr = ((int'(th) << 1) | int'(tt)) & (DEPTH - 1);
      else if (pv)   m_ghr = ((m_ghr << 1) | int'(p)) & (DEPTH - 1);
    end
  endtask

  task automatic idle();
    pv = 0; tv = 0; tt = 0; tm = 0; ppc = '0; tpc = '0; th = '0;
  endtask

  task automatic rand_inputs();
    pv = 1'($urandom); tv = 1'($urandom); tt = 1'($urandom);
    tm = ($urandom_range(0, 3) == 0);
    ppc = $urandom; tpc = $urandom;
    th = ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #2;
    model_reset();
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", init_busy); end
    checks++; if (pt !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", pt); end
    checks++; if (ph !== 8'h00) begin errors++; $display("FAIL reset_hist got %h exp 00", ph); end
`ifdef GSHARE_STATS_EN
    checks++; if (pred_cnt !== 0 || mispred_cnt !== 0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", pred_cnt, mispred_cnt); end
`endif
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Full sweep: busy for exactly DEPTH cycles, traffic ignored throughout.
  task automatic test_init();
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs();
      @(negedge clk);
      checks++; if (init_busy !== 1'b1 || pt !== 1'b0 || ph !== 8'h00) begin
        errors++; $display("FAIL init_cycle%0d got busy=%b pred=%b hist=%h exp 1 0 00", i, init_busy, pt, ph); end
      advance();
    end
    idle();
    @(negedge clk);
    checks++; if (init_busy !== 1'b0) begin errors++; $display("FAIL init_done got %b exp 0", init_busy); end
    advance();
    for (int i = 0; i < 8; i++) begin
      ppc = $urandom;
      @(negedge clk);
      checks++; if (pt !== 1'b0 || pt !== m_pred(ppc)) begin
        errors++; $display("FAIL init_value pc=%h got %b exp 0", ppc, pt); end
      advance();
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      idle(); tv = 1; tpc = 32'h40; th = 8'h00; tt = 1;
      @(negedge clk);
      advance();
    end
    idle(); pv = 1; ppc = 32'h40;
    @(negedge clk);
    checks++; if (pt !== 1'b1) begin errors++; $display("FAIL sat_pred got %b exp 1", pt); end
    checks++; if (ph !== 8'h00) begin errors++; $display("FAIL sat_hist got %h exp 00", ph); end
    advance();
    // one not-taken train: saturated 3 -> 2 still predicts taken; a wrap would not
    idle(); tv = 1; tpc = 32'h40; th = 8'h00; tt = 0;
    @(negedge clk);
    advance();
    idle(); tm = 0;
    @(negedge clk);
    advance();
  endtask

  task automatic test_history();
    // Recover GHR to 0 first.
    idle(); tv = 1; tm = 1; tpc = 32'h400; th = 8'h00; tt = 0;
    @(negedge clk);
    advance();
    for (int i = 0; i < 7; i++) begin
      idle(); pv = 1; ppc = 32'h200 + 32'(i * 4);
      @(negedge clk);
      checks++; if (ph !== 8'h00 || pt !== 1'b0) begin
        errors++; $display("FAIL hist_nt%0d got hist=%h pred=%b exp 00 0", i, ph, pt); end
      advance();
    end
    idle(); pv = 1; ppc = 32'h40;
    @(negedge clk);
    checks++; if (pt !== 1'b1 || ph !== 8'h00) begin
      errors++; $display("FAIL hist_taken got pred=%b hist=%h exp 1 00", pt, ph); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (ph !== 8'h01) begin errors++; $display("FAIL hist_one got %h exp 01", ph); end
    advance();
  endtask

  task automatic test_recovery();
    idle(); tv = 1; tm = 1; tpc = 32'h800; th = 8'h79; tt = 1;
    @(negedge clk);
    advance();
    idle(); tv = 1; tm = 1; tpc = 32'hC00; th = 8'h05; tt = 1; pv = 1; ppc = $urandom;
    @(negedge clk);
    checks++; if (ph !== 8'hF3) begin errors++; $display("FAIL recov_pre got %h exp f3", ph); end
    advance();
    idle();
    @(negedge clk);
    checks++; if (ph !== 8'h0B) begin errors++; $display("FAIL recov_post got %h exp 0b", ph); end
    advance();
  endtask

  task automatic test_rbw();
    logic [31:0] pc;
    pc = 32'h1000;
    for (int c = 0; c < 4 * DEPTH; c++) begin
      pc = 32'h1000 + 32'(c * 4);
      if (m_pht[m_idx(pc, m_ghr)] == 1) break;
    end
    idle(); tv = 1; tpc = pc; th = 8'(m_ghr); tt = 1; ppc = pc;
    @(negedge clk);
    checks++; if (pt !== 1'b0) begin errors++; $display("FAIL rbw_same got %b exp 0", pt); end
    advance();
    idle(); ppc = pc;
    @(negedge clk);
    checks++; if (pt !== 1'b1) begin errors++; $display("FAIL rbw_next got %b exp 1", pt); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      @(negedge clk);
      checks++; if (pt !== m_pred(ppc) || ph !== 8'(m_ghr) || init_busy !== 1'b0) begin
        errors++; $display("FAIL rand%0d got pred=%b hist=%h busy=%b exp %b %h 0",
                           i, pt, ph, init_busy, m_pred(ppc), 8'(m_ghr)); end
      advance();
    end
    idle();
    @(negedge clk);
`ifdef GSHARE_STATS_EN
    checks++; if (pred_cnt !== 32'(m_pc) || mispred_cnt !== 32'(m_mc)) begin
      errors++; $display("FAIL stats got %0d/%0d exp %0d/%0d", pred_cnt, mispred_cnt, m_pc, m_mc); end
`endif
    advance();
  endtask

  // Reset from RUN, then again 7 cycles into the sweep: full sweep restarts.
  task automatic test_reset_midsweep();
    test_reset();
    for (int i = 0; i < 7; i++) begin
      rand_inputs();
      @(negedge clk);
      advance();
    end
    test_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs();
      @(negedge clk);
      checks++; if (init_busy !== 1'b1) begin
        errors++; $display("FAIL resweep_cycle%0d got %b exp 1", i, init_busy); end
      advance();
    end
    idle();
    @(negedge clk);
    checks++; if (init_busy !== 1'b0 || ph !== 8'h00) begin
      errors++; $display("FAIL resweep_done got busy=%b hist=%h exp 0 00", init_busy, ph); end
    advance();
  endtask

  initial begin
    idle();
    test_reset();
    test_init();
    test_saturate();
    test_history();
    test_recovery();
    test_rbw();
    test_random();
    test_reset_midsweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor_param.md
GSHARE_PREDICTOR_PARAM -- requirements
Module: gshare_predictor_param

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width.
REQ-002 SHALL have parameter IDX_W, default 10, PHT index width; PHT depth is 2^IDX_W entries of 2-bit counters.
REQ-003 SHALL have parameter HIST_W, default 10, global history length; legal range 1..IDX_W.
REQ-004 SHALL have parameter PC_LSB, default 2, lowest PC bit used for indexing.
REQ-005 SHALL have parameter CNT_INIT, default 2'b01 (weakly not-taken), PHT initialisation value.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 init_busy  output  1  high while the PHT initialisation sweep runs.
REQ-009 pred_valid  input  1  prediction request qualifier.
REQ-010 pred_pc  input  PC_W  PC of the branch being predicted.
REQ-011 pred_taken  output  1  prediction, combinational from pred_pc and the current speculative GHR.
REQ-012 pred_hist  output  HIST_W  speculative GHR before this prediction's update; the caller carries it to training.
REQ-013 train_valid  input  1  resolved-branch qualifier.
REQ-014 train_pc  input  PC_W  PC of the resolved branch.
REQ-015 train_hist  input  HIST_W  pred_hist captured when this branch was predicted.
REQ-016 train_taken  input  1  actual outcome.
REQ-017 train_mispredict  input  1  resolved outcome differed from the prediction; valid only with train_valid.

Function
REQ-018 Index SHALL be pc[PC_LSB+IDX_W-1:PC_LSB] XOR zero-extended history.
REQ-019 pred_taken SHALL equal PHT[index(pred_pc, GHR)][1] in the same cycle (zero latency); pred_taken SHALL be 0 while init_busy.
REQ-020 On pred_valid with init_busy low and no mispredict, GHR SHALL shift left, inserting pred_taken at bit 0.
REQ-021 On train_valid, the PHT entry at index(train_pc, train_hist) SHALL increment (taken) or decrement (not-taken), saturating at 3 and 0.
REQ-022 On train_valid with train_mispredict, GHR SHALL become {train_hist[HIST_W-2:0], train_taken}, overriding any same-cycle pred_valid update; for HIST_W=1, GHR becomes train_taken.
REQ-023 Same-cycle train and predict to the same index: prediction SHALL use the pre-update counter (read-before-write).
REQ-024 FSM states INIT and RUN: INIT writes CNT_INIT to one entry per cycle starting at entry 0; after entry 2^IDX_W-1 is written, the FSM SHALL move to RUN on the next edge; RUN is terminal until reset.
REQ-025 In INIT, pred_valid and train_valid SHALL be ignored (no PHT or GHR change).
REQ-026 The PHT array SHALL have no reset term, so it maps to RAM; only the FSM and sweep counter, GHR, and statistics counters are reset.

Reset
REQ-027 On rst_n low: FSM=INIT, sweep counter=0, GHR=0, init_busy=1, pred_taken=0, pred_hist=0.
REQ-028 Reset asserted mid-sweep or in RUN SHALL restart the sweep from entry 0.
REQ-029 init_busy SHALL stay high for exactly 2^IDX_W cycles after rst_n deasserts.

Configuration
REQ-030 Macro GSHARE_STATS_EN defined: SHALL add 32-bit outputs pred_cnt (count of accepted pred_valid cycles) and mispred_cnt (count of train_valid and train_mispredict cycles), both reset to 0, saturating at all-ones, frozen during INIT.
REQ-031 Macro GSHARE_STATS_EN undefined: the two ports and their counters SHALL be absent; all other behaviour is identical.

Verification
REQ-032 IDX_W=4: release reset -> init_busy high for exactly 16 cycles, then low; pred_taken=0 for every PC.
REQ-033 After init, train pc=0x40, hist=0, taken, three times -> counter at 3; a fourth train keeps it at 3; predict pc=0x40 with GHR=0 -> pred_taken=1.
REQ-034 Four consecutive pred_valid with pred_taken=0 from GHR=0 -> pred_hist reads 0 each cycle; 3 further not-taken predictions bring GHR to 0; one taken prediction then gives GHR=1.
REQ-035 GHR=0x0F3, train_valid with mispredict, train_hist=0x005, taken, and pred_valid in the same cycle -> next GHR=0x00B (recovery wins).
REQ-036 Same-cycle train (taken) and predict to an index holding 1 -> pred_taken=0 that cycle; next-cycle predict -> 1.
REQ-037 Pulse rst_n low at sweep cycle 7 -> init_busy re-extends a full 2^IDX_W cycles; with GSHARE_STATS_EN, pred_cnt and mispred_cnt read 0.
